// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-port signals around mem_arbiter.
// master is the arbiter's view (it masters the memory port); slave is everything around it.
interface mem_arbiter_if #(
  parameter int addr_width = 48
);
  logic                  i_req;
  logic [addr_width-1:0] i_addr;
  logic [31:0]           i_data;
  logic                  i_ready;

  logic                  d_req;
  logic                  d_we;
  logic [addr_width-1:0] d_addr;
  logic [63:0]           d_wdata;
  logic [63:0]           d_rdata;
  logic                  d_ready;

  logic                  m_req;
  logic                  m_we;
  logic [addr_width-1:0] m_addr;
  logic [63:0]           m_wdata;
  logic [63:0]           m_rdata;
  logic                  m_ready;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    output i_data, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    input  i_data, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch (I) and load/store (D) share one 64-bit port,
// one transaction in flight, D has priority with a streak limit so fetch is not starved.
//
// state  | meaning
// IDLE   | arbitrate between i_req and d_req
// BUSY_I | fetch on the memory port, waiting for m_ready
// BUSY_D | load/store on the memory port, waiting for m_ready
// DONE   | owner's ready pulse is high; return to IDLE
module mem_arbiter #(
  parameter int addr_width   = 48,
  parameter int max_d_streak = 4
) (
  input logic           clk,
  input logic           n_reset,
  mem_arbiter_if.master bus
);
  localparam int            sw         = $clog2(max_d_streak + 1);
  localparam logic [sw-1:0] streak_max = sw'(max_d_streak);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t                state;
  logic [sw-1:0]         streak;
  logic                  m_req;
  logic                  m_we;
  logic [addr_width-1:0] m_addr;
  logic [63:0]           m_wdata;
  logic [31:0]           i_data;
  logic [63:0]           d_rdata;
  logic                  i_ready;
  logic                  d_ready;
  logic                  grant_d;
  logic                  grant_i;

  // D wins unless fetch is waiting and D has already used up its streak
  always_comb begin
    grant_d = bus.d_req && !(bus.i_req && (streak == streak_max));
    grant_i = bus.i_req && !grant_d;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state   <= IDLE;
      streak  <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_data  <= '0;
      d_rdata <= '0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            m_addr  <= bus.d_addr;
            m_we    <= bus.d_we;
            m_wdata <= bus.d_wdata;
            m_req   <= 1'b1;
            state   <= BUSY_D;
            if (!bus.i_req)
              streak <= '0;
            else if (streak != streak_max)
              streak <= streak + 1'b1;
          end else if (grant_i) begin
            m_addr <= bus.i_addr;
            m_we   <= 1'b0;
            m_req  <= 1'b1;
            streak <= '0;
            state  <= BUSY_I;
          end
        end
        BUSY_I: begin
          if (bus.m_ready) begin
            m_req   <= 1'b0;
            // m_addr[2] is the registered i_addr[2], immune to the requester letting go
            i_data  <= m_addr[2] ? bus.m_rdata[63:32] : bus.m_rdata[31:0];
            i_ready <= 1'b1;
            state   <= DONE;
          end
        end
        BUSY_D: begin
          if (bus.m_ready) begin
            m_req <= 1'b0;
            if (!m_we)
              d_rdata <= bus.m_rdata;
            d_ready <= 1'b1;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m_req   = m_req;
  assign bus.m_we    = m_we;
  assign bus.m_addr  = m_addr;
  assign bus.m_wdata = m_wdata;
  assign bus.i_data  = i_data;
  assign bus.d_rdata = d_rdata;
  assign bus.i_ready = i_ready;
  assign bus.d_ready = d_ready;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: directed scenarios plus randomized fetch/load/store
// traffic against a reference memory model and a responding memory with random wait states.
module tb_mem_arbiter;
  localparam int AW   = 48;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic n_reset;
  mem_arbiter_if #(.addr_width(AW)) bus ();

  mem_arbiter #(.addr_width(AW), .max_d_streak(MAXS)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] i_q[$];
  logic [63:0] d_q[$];
  bit          grant_log[$];
  bit          exp_g[$];
  logic [63:0] ref_mem[logic [47:0]];
  logic [63:0] mem[logic [47:0]];
  logic [63:0] last_load = '0;
  logic [47:0] cur_i_addr = '0;
  logic [47:0] cur_d_addr = '0;
  logic        cur_d_we = 1'b0;
  logic [63:0] cur_d_wdata = '0;
  int          mem_waits = 0;
  bit          mem_hold = 1'b0;
  bit          stray_en = 1'b0;
  bit          in_txn = 1'b0;
  int          waits_left = 0;
  int          txn_len = 0;
  int          last_txn_len = 0;
  logic [47:0] al;
  bit          prev_i = 1'b0;
  bit          prev_d = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dflt(input logic [47:0] a);
    return {32'hC0DE_0000 ^ a[31:0], 32'h1234_5678 + a[31:0]};
  endfunction

  function automatic logic [63:0] ref_rd(input logic [47:0] a);
    logic [47:0] k;
    k = {a[47:3], 3'b000};
    return ref_mem.exists(k) ? ref_mem[k] : dflt(k);
  endfunction

  task automatic preload(input logic [47:0] a, input logic [63:0] v);
    ref_mem[a] = v;
    mem[a]     = v;
  endtask

  // Memory: addresses with bit 15 set belong to the data side, the rest to fetch
  always @(negedge clk) begin
    if (bus.m_req === 1'b1) begin
      al = {bus.m_addr[47:3], 3'b000};
      if (!in_txn) begin
        in_txn     = 1'b1;
        txn_len    = 0;
        waits_left = (mem_waits < 0) ? int'($urandom_range(0, 2)) : mem_waits;
        grant_log.push_back(bus.m_addr[15]);
      end
      txn_len++;
      if (bus.m_addr[15]) begin
        check("m_addr_d", 64'(bus.m_addr), 64'(cur_d_addr));
        check("m_we_d", 64'(bus.m_we), 64'(cur_d_we));
        if (cur_d_we) check("m_wdata", bus.m_wdata, cur_d_wdata);
      end else begin
        check("m_addr_i", 64'(bus.m_addr), 64'(cur_i_addr));
        check("m_we_i", 64'(bus.m_we), 64'd0);
      end
      if (mem_hold) begin
        bus.m_ready = 1'b0;
      end else if (waits_left == 0) begin
        bus.m_ready  = 1'b1;
        bus.m_rdata  = mem.exists(al) ? mem[al] : dflt(al);
        if (bus.m_we) mem[al] = bus.m_wdata;
        last_txn_len = txn_len;
      end else begin
        waits_left--;
        bus.m_ready = 1'b0;
      end
    end else begin
      in_txn      = 1'b0;
      bus.m_ready = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.m_rdata = {$urandom, $urandom};
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus.i_ready === 1'b1) begin
      if (i_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL i_ready_unexpected: got pulse expected none");
      end else check("i_data", 64'(bus.i_data), 64'(i_q.pop_front()));
      check("i_ready_len", 64'(prev_i), 64'd0);
    end
    if (bus.d_ready === 1'b1) begin
      if (d_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL d_ready_unexpected: got pulse expected none");
      end else check("d_rdata", bus.d_rdata, d_q.pop_front());
      check("d_ready_len", 64'(prev_d), 64'd0);
    end
    if (bus.i_ready === 1'b1 || bus.d_ready === 1'b1)
      check("ready_excl", 64'(bus.i_ready & bus.d_ready), 64'd0);
    prev_i = (bus.i_ready === 1'b1);
    prev_d = (bus.d_ready === 1'b1);
  end

  task automatic do_fetch(input logic [47:0] a);
    int          n;
    logic [63:0] dw;
    dw = ref_rd(a);
    i_q.push_back(a[2] ? dw[63:32] : dw[31:0]);
    cur_i_addr = a;
    bus.i_addr = a;
    bus.i_req  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.i_ready !== 1'b1 && n < 100);
    if (bus.i_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL i_timeout: got no i_ready expected one within 100 cycles");
    end
    bus.i_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [47:0] a, input logic [63:0] wd);
    int n;
    if (we) ref_mem[a] = wd;
    else    last_load = ref_rd(a);
    d_q.push_back(last_load);
    cur_d_addr  = a;
    cur_d_we    = we;
    cur_d_wdata = wd;
    bus.d_addr  = a;
    bus.d_we    = we;
    bus.d_wdata = wd;
    bus.d_req   = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.d_ready !== 1'b1 && n < 100);
    if (bus.d_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL d_timeout: got no d_ready expected one within 100 cycles");
    end
    bus.d_req = 1'b0;
  endtask

  task automatic rand_data();
    do_data(1'($urandom_range(0, 1)), 48'h8000 + 48'($urandom_range(0, 31)) * 8,
            {$urandom, $urandom});
  endtask

  function automatic logic [47:0] rand_iaddr();
    return 48'h1000 + 48'($urandom_range(0, 255)) * 4;
  endfunction

  // Grant order when both sides keep requesting: D runs of MAXS while I waits, then I
  task automatic predict_grants(input int nd, input int ni);
    int s;
    exp_g.delete();
    s = 0;
    while (nd > 0 || ni > 0) begin
      if (nd > 0 && (ni == 0 || s < MAXS)) begin
        exp_g.push_back(1'b1);
        nd--;
        s = (ni > 0) ? s + 1 : 0;
      end else begin
        exp_g.push_back(1'b0);
        ni--;
        s = 0;
      end
    end
  endtask

  task automatic check_grants(input string name);
    check({name, "_count"}, 64'(grant_log.size()), 64'(exp_g.size()));
    for (int k = 0; k < exp_g.size() && k < grant_log.size(); k++)
      check(name, 64'(grant_log[k]), 64'(exp_g[k]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_req"},   64'(bus.m_req), 64'd0);
    check({tag, "_m_we"},    64'(bus.m_we), 64'd0);
    check({tag, "_m_addr"},  64'(bus.m_addr), 64'd0);
    check({tag, "_m_wdata"}, bus.m_wdata, 64'd0);
    check({tag, "_i_data"},  64'(bus.i_data), 64'd0);
    check({tag, "_d_rdata"}, bus.d_rdata, 64'd0);
    check({tag, "_i_ready"}, 64'(bus.i_ready), 64'd0);
    check({tag, "_d_ready"}, 64'(bus.d_ready), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_reset     = 1'b0;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    n_reset = 1'b1;
    @(negedge clk);

    // zero-wait fetch from the upper word
    preload(48'h1000, 64'hAAAA_BBBB_1111_2222);
    cur_i_addr = 48'h1004;
    bus.i_addr = 48'h1004;
    bus.i_req  = 1'b1;
    i_q.push_back(32'hAAAA_BBBB);
    @(negedge clk);
    check("fetch_m_req", 64'(bus.m_req), 64'd1);
    check("fetch_m_addr", 64'(bus.m_addr), 64'h1004);
    check("fetch_m_we", 64'(bus.m_we), 64'd0);
    @(negedge clk);
    check("fetch_i_ready", 64'(bus.i_ready), 64'd1);
    check("fetch_i_data", 64'(bus.i_data), 64'hAAAA_BBBB);
    bus.i_req = 1'b0;
    @(negedge clk);

    // store then load with two wait states
    mem_waits = 2;
    preload(48'h8008, 64'h55);
    do_data(1'b1, 48'h8000, 64'hDEAD_BEEF_0000_0001);
    check("store_txn_cycles", 64'(last_txn_len), 64'd3);
    do_data(1'b0, 48'h8008, 64'd0);
    check("load_txn_cycles", 64'(last_txn_len), 64'd3);
    mem_waits = 0;
    @(negedge clk);

    // both requests held: priority with forced fetch after MAXS data grants
    grant_log.delete();
    fork
      begin repeat (2) do_fetch(rand_iaddr()); end
      begin repeat (8) rand_data(); end
    join
    predict_grants(8, 2);
    check_grants("prio_order");
    @(negedge clk);

    // streak cleared by a data grant without a pending fetch
    bus.i_addr = 48'h1100;
    cur_i_addr = 48'h1100;
    bus.i_req  = 1'b1;
    repeat (3) rand_data();
    bus.i_req = 1'b0;
    rand_data();
    grant_log.delete();
    fork
      begin do_fetch(48'h1100); end
      begin repeat (5) rand_data(); end
    join
    predict_grants(5, 1);
    check_grants("streak_clear");
    @(negedge clk);

    // reset while a load is stalled, then stray m_ready while idle
    mem_hold    = 1'b1;
    cur_d_addr  = 48'h8010;
    cur_d_we    = 1'b0;
    bus.d_addr  = 48'h8010;
    bus.d_we    = 1'b0;
    bus.d_req   = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.m_req !== 1'b1 && n < 20);
    check("hold_m_req", 64'(bus.m_req), 64'd1);
    @(negedge clk);
    n_reset = 1'b0;
    @(negedge clk);
    n_reset   = 1'b1;
    bus.d_req = 1'b0;
    mem_hold  = 1'b0;
    stray_en  = 1'b1;
    last_load = '0;
    repeat (8) @(negedge clk);
    stray_en = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // randomized traffic with random wait states
    mem_waits = -1;
    fork
      begin
        repeat (25) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          do_fetch(rand_iaddr());
        end
      end
      begin
        repeat (30) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          rand_data();
        end
      end
    join
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the instruction-fetch side and the load/store side of the RV64 core. Both requesters share one 64-bit memory port with a req/ready handshake. One transaction is in flight at a time. Data-side requests have priority, and a streak counter guarantees that fetch is not starved.

## Interface
- addr_width, 48, byte address width on all ports
- max_d_streak, 4, maximum consecutive D grants while i_req is pending before I is forced (≥1)
- clk  in  1  clock, rising edge
- n_reset  in  1  synchronous, active-low reset
- i_req  in  1  fetch request; i_addr held stable until i_ready
- i_addr  in  addr_width  fetch byte address (4-byte aligned)
- i_data  out  32  fetched instruction, valid when i_ready=1, held until next I completion
- i_ready  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; d_we/d_addr/d_wdata held stable until d_ready
- d_we  in  1  1=store, 0=load
- d_addr  in  addr_width  data byte address (8-byte aligned)
- d_wdata  in  64  store data
- d_rdata  out  64  load data, valid when d_ready=1 after a load, held until next load completion
- d_ready  out  1  one-cycle completion pulse for load or store
- m_req  out  1  memory request, held until m_ready sampled high
- m_we  out  1  memory write enable
- m_addr  out  addr_width  memory byte address; memory ignores m_addr[2:0] and returns the aligned doubleword
- m_wdata  out  64  memory write data
- m_rdata  in  64  memory read data, valid in the m_ready cycle
- m_ready  in  1  memory completion, sampled only while m_req=1

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE, arbitration on each edge:
  - d_req only: grant D.
  - i_req only: grant I.
  - Both requests, streak < max_d_streak: grant D.
  - Both requests, streak == max_d_streak: grant I.
  - No request: stay in IDLE.
- On grant:
  - Register m_addr from the granted address. For D, also register m_we=d_we and m_wdata=d_wdata. For I, m_we=0 and m_wdata is unchanged.
  - Set m_req=1 and move to BUSY_I or BUSY_D.
- Streak counter:
  - D grant with i_req=1: +1, saturating at max_d_streak.
  - D grant with i_req=0: cleared.
  - I grant: cleared.
- BUSY_x:
  - m_req=1 with all m_* outputs stable.
  - On m_ready=1: drop m_req, latch the read data, move to DONE with owner x.
  - BUSY_I latch: i_data = i_addr[2] ? m_rdata[63:32] : m_rdata[31:0].
  - BUSY_D latch: d_rdata = m_rdata for a load only; a store leaves d_rdata unchanged.
- DONE:
  - Assert the owner's ready (i_ready or d_ready) for exactly one cycle.
  - Go to IDLE unconditionally.
- A requester still holding req in the IDLE cycle after its ready pulse is treated as a new request.
- m_ready is ignored in IDLE and DONE.
- If a requester drops req mid-transaction (protocol violation), the transaction still completes and ready still pulses.

## Timing
- Reset, n_reset=0 sampled at an edge:
  - State = IDLE, streak = 0.
  - m_req=0, m_we=0, m_addr=0, m_wdata=0, i_data=0, d_rdata=0, i_ready=0, d_ready=0.
  - Any in-flight transaction is abandoned; a late m_ready is ignored.
- Minimum latency with a zero-wait memory:
  - Req seen at edge k.
  - m_req high in cycle k+1 (edge k → k+1).
  - m_ready in cycle k+1, so x_ready is high in cycle k+2.
  - Request-to-ready = 2 cycles; throughput = 1 transaction per 3 cycles.
- Each memory wait state adds 1 cycle.
- i_ready and d_ready are never high in the same cycle and are never high for more than 1 cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Zero-wait single fetch:
  - Stimulus: i_addr=0x1004; memory returns 0xAAAA_BBBB_1111_2222 with m_ready in the first m_req cycle.
  - Response: m_addr=0x1004 and m_we=0 one cycle after the request; i_ready=1 two cycles after the request with i_data=0xAAAA_BBBB.
- Store then load with 2 wait states:
  - Stimulus: store of d_wdata=0xDEAD_BEEF_0000_0001, then a load returning 0x55.
  - Response: m_we=1 with stable m_wdata for 3 cycles; d_ready after the store leaves d_rdata=0; d_ready after the load gives d_rdata=0x55.
- Priority and anti-starvation:
  - Stimulus: i_req and d_req held high continuously, default max_d_streak=4.
  - Response: grant order D,D,D,D,I,D,D,D,D,I.
- Streak clear:
  - Stimulus: 3 D grants with i_req=1, then 1 D grant with i_req=0, then both requests.
  - Response: next 4 grants are D before I.
- Reset mid-transaction:
  - Stimulus: n_reset=0 for one edge during BUSY_D; memory then asserts m_ready.
  - Response: all outputs at their reset values, no d_ready, state IDLE.
- Stray m_ready:
  - Stimulus: m_ready pulses while in IDLE.
  - Response: no ready pulse, outputs unchanged.
